// File: rtl/poly_arith_unit.sv
// Coefficient-wise polynomial micro-op engine: ADD, SUB, COMPRESS and DECOMPRESS over
// a 256-coefficient slot, streamed from the slot bank and written back in order.
module poly_arith_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cmd_op,
    input  logic [4:0]  cmd_slot_a,
    input  logic [4:0]  cmd_slot_b,
    input  logic [3:0]  cmd_param,
    input  logic        cmd_start,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic        busy,
    output logic        rd_a_en,
    output logic [12:0] rd_a_addr,
    input  logic [11:0] rd_a_data,
    output logic        rd_b_en,
    output logic [12:0] rd_b_addr,
    input  logic [11:0] rd_b_data,
    output logic        wr_en,
    output logic [12:0] wr_addr,
    output logic [11:0] wr_data
);

    localparam int unsigned Q       = 3329;
    localparam int unsigned N       = 256;
    localparam int unsigned COEFF_W = 12;
    localparam int unsigned SLOT_W  = 5;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned D_W     = 4;
    localparam int unsigned PROD_W  = 24;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(9);
    localparam logic [OP_W-1:0] OP_CMP = OP_W'(10);
    localparam logic [OP_W-1:0] OP_DEC = OP_W'(11);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              state_q, state_nx;
    logic [IDX_W-1:0]    idx_q, idx_nx;
    logic [OP_W-1:0]     op_q, op_nx;
    logic [SLOT_W-1:0]   slot_a_q, slot_a_nx;
    logic [SLOT_W-1:0]   slot_b_q, slot_b_nx;
    logic [D_W-1:0]      d_q, d_nx;

    logic                busy_nx, done_nx, err_nx;
    logic                rd_a_en_nx, rd_b_en_nx;
    logic [12:0]         rd_a_addr_nx, rd_b_addr_nx;

    logic                op_valid, op_pack, d_legal;

    // Command decode
    always_comb begin
        op_valid = (cmd_op == OP_ADD) || (cmd_op == OP_SUB) ||
                   (cmd_op == OP_CMP) || (cmd_op == OP_DEC);
        op_pack  = (cmd_op == OP_CMP) || (cmd_op == OP_DEC);
        d_legal  = (cmd_param == D_W'(1))  || (cmd_param == D_W'(4)) ||
                   (cmd_param == D_W'(5))  || (cmd_param == D_W'(10)) ||
                   (cmd_param == D_W'(11));
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx  = state_q;
        idx_nx    = idx_q;
        op_nx     = op_q;
        slot_a_nx = slot_a_q;
        slot_b_nx = slot_b_q;
        d_nx      = d_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_start && op_valid) begin
                    op_nx     = cmd_op;
                    slot_a_nx = cmd_slot_a;
                    slot_b_nx = cmd_slot_b;
                    d_nx      = cmd_param;
                    idx_nx    = '0;
                    state_nx  = (op_pack && !d_legal) ? S_ERR : S_RUN;
                end
            end
            S_RUN: begin
                idx_nx = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N - 1)) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // idx restarts at 0 here and counts the two pipeline flush cycles
                idx_nx = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(1)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        busy_nx      = (state_nx != S_IDLE);
        done_nx      = (state_nx == S_DONE) || (state_nx == S_ERR);
        err_nx       = (state_nx == S_ERR);
        rd_a_en_nx   = (state_nx == S_RUN);
        rd_b_en_nx   = rd_a_en_nx && ((op_nx == OP_ADD) || (op_nx == OP_SUB));
        rd_a_addr_nx = rd_a_en_nx ? {slot_a_nx, idx_nx} : '0;
        rd_b_addr_nx = rd_b_en_nx ? {slot_b_nx, idx_nx} : '0;
    end

    // State and registered control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            op_q      <= '0;
            slot_a_q  <= '0;
            slot_b_q  <= '0;
            d_q       <= '0;
            busy      <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
            rd_a_en   <= 1'b0;
            rd_b_en   <= 1'b0;
            rd_a_addr <= '0;
            rd_b_addr <= '0;
        end else begin
            state_q   <= state_nx;
            idx_q     <= idx_nx;
            op_q      <= op_nx;
            slot_a_q  <= slot_a_nx;
            slot_b_q  <= slot_b_nx;
            d_q       <= d_nx;
            busy      <= busy_nx;
            cmd_done  <= done_nx;
            cmd_err   <= err_nx;
            rd_a_en   <= rd_a_en_nx;
            rd_b_en   <= rd_b_en_nx;
            rd_a_addr <= rd_a_addr_nx;
            rd_b_addr <= rd_b_addr_nx;
        end
    end

    logic [COEFF_W:0]   add_sum, add_red, sub_dif, sub_red;
    logic [PROD_W-1:0]  d_mask, cmp_num, cmp_quo, dec_num;
    logic [COEFF_W-1:0] res_c;
    logic [SLOT_W-1:0]  dst_slot;

    // Coefficient arithmetic on the returning read data
    always_comb begin
        add_sum = {1'b0, rd_a_data} + {1'b0, rd_b_data};
        add_red = (add_sum >= (COEFF_W + 1)'(Q)) ? add_sum - (COEFF_W + 1)'(Q) : add_sum;
        sub_dif = {1'b0, rd_a_data} - {1'b0, rd_b_data};
        sub_red = (rd_a_data < rd_b_data) ? sub_dif + (COEFF_W + 1)'(Q) : sub_dif;

        d_mask  = (PROD_W'(1) << d_q) - PROD_W'(1);
        // Exact floor division by the constant modulus
        cmp_num = (PROD_W'(rd_a_data) << d_q) + PROD_W'((Q - 1) / 2);
        cmp_quo = cmp_num / PROD_W'(Q);
        dec_num = (PROD_W'(rd_a_data) & d_mask) * PROD_W'(Q) +
                  (PROD_W'(1) << (d_q - D_W'(1)));

        case (op_q)
            OP_ADD:  res_c = COEFF_W'(add_red);
            OP_SUB:  res_c = COEFF_W'(sub_red);
            OP_CMP:  res_c = COEFF_W'(cmp_quo & d_mask);
            default: res_c = COEFF_W'(dec_num >> d_q);
        endcase

        dst_slot = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? slot_a_q : slot_b_q;
    end

    logic               rd_vld_q;
    logic [IDX_W-1:0]   rd_idx_q;

    // Read-return tracking and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            rd_vld_q <= rd_a_en;
            rd_idx_q <= idx_q;
            wr_en    <= rd_vld_q;
            if (rd_vld_q) begin
                wr_addr <= {dst_slot, rd_idx_q};
                wr_data <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_poly_arith_unit.sv
// Bench for poly_arith_unit: slot-bank model, directed vector table, timing corners
// and randomized runs against an arithmetic reference model.
module tb_poly_arith_unit;

    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_slot_a, cmd_slot_b;
    logic [3:0]  cmd_param;
    logic        cmd_start;
    logic        cmd_done, cmd_err, busy;
    logic        rd_a_en, rd_b_en, wr_en;
    logic [12:0] rd_a_addr, rd_b_addr, wr_addr;
    logic [11:0] rd_a_data, rd_b_data, wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    poly_arith_unit dut (
        .clk(clk), .rst(rst),
        .cmd_op(cmd_op), .cmd_slot_a(cmd_slot_a), .cmd_slot_b(cmd_slot_b),
        .cmd_param(cmd_param), .cmd_start(cmd_start),
        .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy),
        .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
        .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // Slot bank: 32 slots x 256 coefficients, 1-cycle read latency
    logic [11:0] mem [0:8191];
    always @(posedge clk) begin
        if (rd_a_en) rd_a_data <= mem[rd_a_addr];
        if (rd_b_en) rd_b_data <= mem[rd_b_addr];
        if (wr_en)   mem[wr_addr] = wr_data;
    end

    typedef struct {
        int done_cyc;
        int done_cnt;
        int err_cnt;
        int wr_cnt;
        int bad_cnt;
        int rda_cnt;
        int rdb_cnt;
        int busy_cnt;
    } res_t;

    typedef struct {
        int op;
        int d;
        int sa;
        int sb;
        int a;
        int b;
        int exp;
    } vec_t;

    vec_t vecs [15];
    int   exp_c [256];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int model(input int op, input int d, input int a, input int b);
        case (op)
            8:       return (a + b) % Q;
            9:       return (a - b + Q) % Q;
            10:      return ((a * (1 << d) + (Q - 1) / 2) / Q) % (1 << d);
            default: return ((a % (1 << d)) * Q + (1 << (d - 1))) / (1 << d);
        endcase
    endfunction

    task automatic fill_slot(input int s, input int v);
        for (int i = 0; i < 256; i++) mem[s * 256 + i] = 12'(v);
    endtask

    // Issue one command at cycle T and observe cycles T+1..T+ncyc
    task automatic run_cmd(input int op, input int sa, input int sb, input int d,
                           input int restart_at, input int rst_at, input int ncyc,
                           output res_t r);
        logic [4:0] dst;
        dst = 5'((op == 8 || op == 9) ? sa : sb);
        r = '{default: 0};
        r.done_cyc = -1;
        @(negedge clk);
        cmd_op = 4'(op); cmd_slot_a = 5'(sa); cmd_slot_b = 5'(sb);
        cmd_param = 4'(d); cmd_start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (cmd_done) begin
                r.done_cnt++;
                if (r.done_cyc < 0) r.done_cyc = k;
            end
            if (cmd_err) r.err_cnt++;
            if (busy)    r.busy_cnt++;
            if (rd_a_en) begin
                r.rda_cnt++;
                if (rd_a_addr != {5'(sa), 8'(k - 1)}) r.bad_cnt++;
            end
            if (rd_b_en) begin
                r.rdb_cnt++;
                if (rd_b_addr != {5'(sb), 8'(k - 1)}) r.bad_cnt++;
            end
            if (wr_en) begin
                r.wr_cnt++;
                if (wr_addr != {dst, 8'(k - 3)}) r.bad_cnt++;
            end
            cmd_start = (k == restart_at);
            if (k == restart_at) begin
                cmd_op = 4'd8; cmd_slot_a = 5'd20; cmd_slot_b = 5'd21;
            end
            rst = (k == rst_at);
        end
        cmd_start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic check_normal(input string tag, input res_t r, input int op);
        chk({tag, " done_cycle"}, r.done_cyc, 259);
        chk({tag, " done_count"}, r.done_cnt, 1);
        chk({tag, " err_count"}, r.err_cnt, 0);
        chk({tag, " writes"}, r.wr_cnt, 256);
        chk({tag, " addr_errors"}, r.bad_cnt, 0);
        chk({tag, " busy_cycles"}, r.busy_cnt, 259);
        chk({tag, " rd_b_reads"}, r.rdb_cnt, (op == 8 || op == 9) ? 256 : 0);
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        res_t r;
        int dst, idx, nb;
        string tag;
        v = vecs[vi];
        tag = $sformatf("vec%0d", vi);
        dst = (v.op == 8 || v.op == 9) ? v.sa : v.sb;
        if (v.sb != v.sa) fill_slot(v.sb, (v.op == 8 || v.op == 9) ? v.b : 4095);
        fill_slot(v.sa, v.a);
        run_cmd(v.op, v.sa, v.sb, v.d, 0, 0, 262, r);
        check_normal(tag, r, v.op);
        idx = 0;
        for (int i = 255; i >= 0; i--) if (int'(mem[dst * 256 + i]) != v.exp) idx = i;
        chk($sformatf("%s data[%0d]", tag, idx), int'(mem[dst * 256 + idx]), v.exp);
        if ((v.op == 8 || v.op == 9) && v.sb != v.sa) begin
            nb = 0;
            for (int i = 0; i < 256; i++) if (int'(mem[v.sb * 256 + i]) != v.b) nb++;
            chk({tag, " src_b_changed"}, nb, 0);
        end
    endtask

    task automatic run_rand(input int ri);
        int op, d, sa, sb, nb;
        int dlist [5];
        res_t r;
        dlist = '{1, 4, 5, 10, 11};
        op = 8 + int'($urandom_range(0, 3));
        d  = dlist[$urandom_range(0, 4)];
        sa = 8 + int'($urandom_range(0, 23));
        sb = ($urandom_range(0, 3) == 0) ? sa : 8 + int'($urandom_range(0, 23));
        for (int i = 0; i < 256; i++) begin
            if (sb != sa) mem[sb * 256 + i] = 12'($urandom_range(0, Q - 1));
            mem[sa * 256 + i] = (op == 11) ? 12'($urandom_range(0, 4095))
                                           : 12'($urandom_range(0, Q - 1));
        end
        for (int i = 0; i < 256; i++)
            exp_c[i] = model(op, d, int'(mem[sa * 256 + i]), int'(mem[sb * 256 + i]));
        run_cmd(op, sa, sb, d, 0, 0, 262, r);
        check_normal($sformatf("rand%0d op%0d d%0d", ri, op, d), r, op);
        nb = 0;
        for (int i = 0; i < 256; i++)
            if (int'(mem[((op == 8 || op == 9) ? sa : sb) * 256 + i]) != exp_c[i]) nb++;
        chk($sformatf("rand%0d data_mismatches", ri), nb, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        vecs[0]  = '{8,  0, 0, 1, 3000, 500, 171};
        vecs[1]  = '{9,  0, 3, 0, 5,    10,  3324};
        vecs[2]  = '{9,  0, 3, 0, 10,   5,   5};
        vecs[3]  = '{10, 1, 4, 5, 832,  0,   0};
        vecs[4]  = '{10, 1, 4, 5, 833,  0,   1};
        vecs[5]  = '{10, 1, 4, 5, 2496, 0,   1};
        vecs[6]  = '{10, 1, 4, 5, 2497, 0,   0};
        vecs[7]  = '{10, 10, 4, 5, 3328, 0,  0};
        vecs[8]  = '{10, 5, 4, 5, 1664, 0,   16};
        vecs[9]  = '{10, 11, 4, 5, 1,   0,   1};
        vecs[10] = '{11, 10, 6, 6, 1023, 0,  3326};
        vecs[11] = '{11, 4, 7, 7, 8,    0,   1665};
        vecs[12] = '{11, 4, 7, 7, 248,  0,   1665};
        vecs[13] = '{11, 11, 8, 9, 2047, 0,  3327};
        vecs[14] = '{11, 1, 8, 9, 1,    0,   1665};

        for (int i = 0; i < 8192; i++) mem[i] = 12'd0;
        rst = 1'b1; cmd_start = 1'b0; cmd_op = '0;
        cmd_slot_a = '0; cmd_slot_b = '0; cmd_param = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs", int'({cmd_done, cmd_err, busy, rd_a_en, rd_b_en, wr_en}), 0);
        chk("reset buses", int'(rd_a_addr | rd_b_addr | wr_addr | 13'(wr_data)), 0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(i);

        // Illegal D: immediate error completion, no bank traffic
        fill_slot(5, 4095);
        run_cmd(10, 4, 5, 3, 0, 0, 10, r);
        chk("errD done_cycle", r.done_cyc, 1);
        chk("errD err_count", r.err_cnt, 1);
        chk("errD done_count", r.done_cnt, 1);
        chk("errD writes", r.wr_cnt, 0);
        chk("errD reads", r.rda_cnt + r.rdb_cnt, 0);
        chk("errD busy_cycles", r.busy_cnt, 1);

        // Unhandled opcode: no response at all
        run_cmd(3, 4, 5, 4, 0, 0, 20, r);
        chk("op3 activity", r.done_cnt + r.busy_cnt + r.rda_cnt + r.wr_cnt, 0);

        // Second start mid-run is ignored
        fill_slot(0, 3000);
        fill_slot(1, 500);
        run_cmd(8, 0, 1, 0, 50, 0, 262, r);
        check_normal("restart", r, 8);
        chk("restart data", int'(mem[0 * 256 + 200]), 171);

        // Reset mid-run aborts without completion
        fill_slot(10, 100);
        fill_slot(11, 200);
        run_cmd(8, 10, 11, 0, 0, 100, 300, r);
        chk("abort done_count", r.done_cnt, 0);
        chk("abort writes", r.wr_cnt, 98);
        chk("abort addr_errors", r.bad_cnt, 0);
        chk("abort busy_cycles", r.busy_cnt, 100);

        // Fresh ADD after reset
        run_vec(0);

        for (int i = 0; i < 10; i++) run_rand(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
